// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings and FSM state type for the HI/LO unit
// Purpose: req_op encodings, controller state enum, and op classification helper.
// Ports: none (package).

package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DIV_REQ  = 3'd1,
        DIV_BUSY = 3'd2,
        MUL_BUSY = 3'd3,
        DONE     = 3'd4,
        DRAIN    = 3'd5
    } muldiv_state_e;

    // Multi-cycle ops that occupy the unit and stall the pipeline.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_mul.sv
// rtl/muldiv_mul.sv - 2-stage pipelined 32x32 signed/unsigned multiplier
// Purpose: stage 1 captures sign-extended operands, stage 2 registers the
//          64-bit product; product is valid two cycles after in_valid.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid            launch a multiply with a/b this cycle
//   is_signed           treat a/b as two's-complement
//   a, b                32-bit operands
//   out_valid, product  64-bit result, valid two cycles after launch

module muldiv_mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [63:0] product
);

    // A 33-bit signed form lets one multiplier serve both signed and unsigned ops.
    logic signed [32:0] a_s1;
    logic signed [32:0] b_s1;
    logic               v_s1;
    logic signed [63:0] prod_s1;

    assign prod_s1 = 64'(a_s1) * 64'(b_s1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_s1      <= '0;
            b_s1      <= '0;
            v_s1      <= 1'b0;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            v_s1      <= in_valid;
            out_valid <= v_s1;
            if (in_valid) begin
                a_s1 <= {is_signed & a[31], a};
                b_s1 <= {is_signed & b[31], b};
            end
            if (v_s1) begin
                product <= prod_s1;
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide sequencing controller
// Purpose: accepts EX-stage MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs the internal
//          multiplier or the external divider handshake, stalls the pipeline
//          and writes HI/LO. Optional macro MULDIV_HILO_FWD_EN adds
//          fwd_valid/fwd_data presenting the DONE-cycle result for bypass.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid, req_op, src_a, src_b  EX-stage request and rs/rt operands
//   ex_ex, int_flush                 exception suppress, pipeline flush
//   div_tvalid/div_tready            divider request handshake
//   div_sign, div_a, div_b           divider request payload
//   div_out_valid, div_quot, div_rem divider response
//   stall                            hold EX and earlier stages
//   hilo_we, hilo_wdata              [1]=HI [0]=LO write, data {HI,LO}
//   busy                             FSM not IDLE
//   fwd_valid, fwd_data              (MULDIV_HILO_FWD_EN only) bypass result

module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        ex_ex,
    input  logic        int_flush,
    output logic        div_tvalid,
    output logic        div_sign,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_tready,
    input  logic        div_out_valid,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
`ifdef MULDIV_HILO_FWD_EN
    output logic        fwd_valid,
    output logic [63:0] fwd_data,
`endif
    output logic        stall,
    output logic [1:0]  hilo_we,
    output logic [63:0] hilo_wdata,
    output logic        busy
);

    muldiv_state_e state_q, state_d;

    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] res_q;

    logic        load_ops;
    logic        mul_start;
    logic        cap_div;
    logic        mul_valid;
    logic [63:0] mul_product;
    logic        op_is_mul_q;
    logic [63:0] done_data;

    // The multiplier is fed straight from the operand bus in the accepting
    // cycle so its product lands exactly in DONE.
    muldiv_mul u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (mul_start),
        .is_signed (req_op == OP_MULT),
        .a         (src_a),
        .b         (src_b),
        .out_valid (mul_valid),
        .product   (mul_product)
    );

    assign op_is_mul_q = (op_q == OP_MULT) || (op_q == OP_MULTU);
    assign done_data   = (op_is_mul_q && mul_valid) ? mul_product : res_q;

    assign div_a    = a_q;
    assign div_b    = b_q;
    assign div_sign = (op_q == OP_DIV);
    assign busy     = (state_q != IDLE);

`ifdef MULDIV_HILO_FWD_EN
    assign fwd_valid = (state_q == DONE) && !int_flush;
    assign fwd_data  = done_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_ops) begin
                op_q <= req_op;
                a_q  <= src_a;
                b_q  <= src_b;
            end
            if (cap_div) begin
                res_q <= {div_rem, div_quot};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        hilo_we    = 2'b00;
        hilo_wdata = '0;
        div_tvalid = 1'b0;
        load_ops   = 1'b0;
        mul_start  = 1'b0;
        cap_div    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rst_n && req_valid && !ex_ex && !int_flush) begin
                    case (req_op)
                        OP_MTHI: begin
                            hilo_we    = 2'b10;
                            hilo_wdata = {src_a, 32'h0};
                        end
                        OP_MTLO: begin
                            hilo_we    = 2'b01;
                            hilo_wdata = {32'h0, src_a};
                        end
                        OP_MULT, OP_MULTU: begin
                            stall     = 1'b1;
                            load_ops  = 1'b1;
                            mul_start = 1'b1;
                            state_d   = MUL_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            stall    = 1'b1;
                            load_ops = 1'b1;
                            state_d  = DIV_REQ;
                        end
                        default: ;
                    endcase
                end
            end

            DIV_REQ: begin
                // tvalid stays up through a flush: if the divider takes it
                // this cycle the response still has to be drained.
                div_tvalid = 1'b1;
                stall      = !int_flush;
                if (int_flush) begin
                    state_d = div_tready ? DRAIN : IDLE;
                end else if (div_tready) begin
                    state_d = DIV_BUSY;
                end
            end

            DIV_BUSY: begin
                stall = !int_flush;
                if (int_flush) begin
                    state_d = div_out_valid ? IDLE : DRAIN;
                end else if (div_out_valid) begin
                    cap_div = 1'b1;
                    state_d = DONE;
                end
            end

            MUL_BUSY: begin
                stall   = !int_flush;
                state_d = int_flush ? IDLE : DONE;
            end

            DONE: begin
                if (!int_flush) begin
                    hilo_we    = 2'b11;
                    hilo_wdata = done_data;
                end
                state_d = IDLE;
            end

            DRAIN: begin
                // A waiting long op must not slip past while the stale
                // divider response is still outstanding.
                stall = req_valid && is_long_op(req_op) && !int_flush;
                if (div_out_valid) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl

module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] src_a, src_b;
    logic        ex_ex, int_flush;
    logic        div_tvalid, div_sign, div_tready, div_out_valid;
    logic [31:0] div_a, div_b, div_quot, div_rem;
    logic        stall, busy;
    logic [1:0]  hilo_we;
    logic [63:0] hilo_wdata;
`ifdef MULDIV_HILO_FWD_EN
    logic        fwd_valid;
    logic [63:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .src_a         (src_a),
        .src_b         (src_b),
        .ex_ex         (ex_ex),
        .int_flush     (int_flush),
        .div_tvalid    (div_tvalid),
        .div_sign      (div_sign),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_tready    (div_tready),
        .div_out_valid (div_out_valid),
        .div_quot      (div_quot),
        .div_rem       (div_rem),
`ifdef MULDIV_HILO_FWD_EN
        .fwd_valid     (fwd_valid),
        .fwd_data      (fwd_data),
`endif
        .stall         (stall),
        .hilo_we       (hilo_we),
        .hilo_wdata    (hilo_wdata),
        .busy          (busy)
    );

    // Divider responder: tready after rdy_dly waiting cycles, result res_dly
    // cycles after the handshake. Divide-by-zero returns quot=all-ones, rem=a.
    int          rdy_dly = 0;
    int          res_dly = 1;
    int          req_wait;
    int          cnt;
    logic        pend;
    logic [31:0] q_r, r_r;

    always @(posedge clk) begin
        if (!rst_n) begin
            req_wait <= 0;
            pend     <= 1'b0;
            cnt      <= 0;
            q_r      <= '0;
            r_r      <= '0;
        end else if (div_tvalid && div_tready) begin
            req_wait <= 0;
            pend     <= 1'b1;
            cnt      <= 1;
            if (div_b == 32'd0) begin
                q_r <= 32'hFFFF_FFFF;
                r_r <= div_a;
            end else if (div_sign) begin
                q_r <= $signed(div_a) / $signed(div_b);
                r_r <= $signed(div_a) % $signed(div_b);
            end else begin
                q_r <= div_a / div_b;
                r_r <= div_a % div_b;
            end
        end else begin
            req_wait <= div_tvalid ? req_wait + 1 : 0;
            if (div_out_valid) pend <= 1'b0;
            else if (pend)     cnt  <= cnt + 1;
        end
    end

    assign div_tready    = div_tvalid && (req_wait >= rdy_dly);
    assign div_out_valid = pend && (cnt >= res_dly);
    assign div_quot      = q_r;
    assign div_rem       = r_r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op (called at posedge+1), hold req_valid while stalled, and
    // record stall/tvalid cycle counts and the HI/LO write.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int rd, input int rs,
                          output int n_stall, output int n_tv,
                          output logic [1:0] we, output logic [63:0] wd, output logic to);
        rdy_dly   = rd;
        res_dly   = rs;
        req_valid = 1'b1;
        req_op    = op;
        src_a     = a;
        src_b     = b;
        n_stall   = 0;
        n_tv      = 0;
        we        = 2'b00;
        wd        = '0;
        to        = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (stall)      n_stall++;
            if (div_tvalid) n_tv++;
            if (hilo_we != 2'b00) begin
                we = hilo_we;
                wd = hilo_wdata;
                to = 1'b0;
            end
            step();
            if (!to) break;
        end
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          rd;
        int          rs;
        int          exp_stall;
        int          exp_tv;
        logic [1:0]  exp_we;
        logic [63:0] exp_wd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int          ns, ntv, idx, nlow;
        logic [1:0]  we;
        logic [63:0] wd;
        logic        to;

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        0, 1,  2, 0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1,  2, 0, 2'b11, 64'hFFFF_FFFE_0000_0001};
        vecs[2]  = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 0, 1,  2, 0, 2'b11, 64'h0000_0001_0000_0000};
        vecs[3]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 0, 1,  2, 0, 2'b11, 64'h4000_0000_0000_0000};
        vecs[4]  = '{OP_MULT,  32'hFFFF_FFFF, 32'd7,        0, 1,  2, 0, 2'b11, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[5]  = '{OP_DIVU,  32'd100,       32'd7,        3, 5, 10, 4, 2'b11, 64'h0000_0002_0000_000E};
        vecs[6]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        0, 1,  3, 1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[7]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 0, 1,  3, 1, 2'b11, 64'h0000_0001_FFFF_FFFD};
        vecs[8]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd2,        1, 2,  5, 2, 2'b11, 64'h0000_0001_7FFF_FFFF};
        vecs[9]  = '{OP_DIV,   32'd5,         32'd0,        0, 1,  3, 1, 2'b11, 64'h0000_0005_FFFF_FFFF};
        vecs[10] = '{OP_MTHI,  32'h0000_1234, 32'd0,        0, 1,  0, 0, 2'b10, 64'h0000_1234_0000_0000};
        vecs[11] = '{OP_MTLO,  32'hCAFE_BABE, 32'd0,        0, 1,  0, 0, 2'b01, 64'h0000_0000_CAFE_BABE};

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; src_a = '0; src_b = '0;
        ex_ex = 1'b0; int_flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_we", hilo_we, 0);
        chk("rst_wdata", hilo_wdata, 0);
        chk("rst_tvalid", div_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div_a", div_a, 0);
        step();
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].rs, ns, ntv, we, wd, to);
            chk($sformatf("v%0d_timeout", i), to, 0);
            chk($sformatf("v%0d_stall_cycles", i), ns, vecs[i].exp_stall);
            chk($sformatf("v%0d_tvalid_cycles", i), ntv, vecs[i].exp_tv);
            chk($sformatf("v%0d_we", i), we, vecs[i].exp_we);
            chk($sformatf("v%0d_wdata", i), wd, vecs[i].exp_wd);
            @(negedge clk);
            chk($sformatf("v%0d_idle_after", i), busy, 0);
            step();
        end

        // MTHI suppressed by exception, then accepted
        req_valid = 1'b1; req_op = OP_MTHI; src_a = 32'h1234; ex_ex = 1'b1;
        @(negedge clk);
        chk("mthi_exc_we", hilo_we, 2'b00);
        chk("mthi_exc_stall", stall, 0);
        step();
        ex_ex = 1'b0;
        @(negedge clk);
        chk("mthi_we", hilo_we, 2'b10);
        chk("mthi_hi", hilo_wdata[63:32], 32'h1234);
        chk("mthi_stall", stall, 0);
        step();

        // MULT presented with flush in IDLE is not accepted
        req_op = OP_MULT; src_a = 32'd3; src_b = 32'd4; int_flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_stall", stall, 0);
        step();
        req_valid = 1'b0; int_flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", busy, 0);
        step();

        // flush in MUL_BUSY
        req_valid = 1'b1; req_op = OP_MULT; src_a = 32'd3; src_b = 32'd4;
        step();
        req_valid = 1'b0; int_flush = 1'b1;
        @(negedge clk);
        chk("mulbusy_flush_stall", stall, 0);
        chk("mulbusy_flush_we", hilo_we, 0);
        step();
        int_flush = 1'b0;
        @(negedge clk);
        chk("mulbusy_flush_we_next", hilo_we, 0);
        chk("mulbusy_flush_busy", busy, 0);
        step();

        // flush in DONE suppresses the write
        req_valid = 1'b1; req_op = OP_MULTU; src_a = 32'd5; src_b = 32'd6;
        step();
        step();
        int_flush = 1'b1;
        @(negedge clk);
        chk("done_flush_we", hilo_we, 0);
        chk("done_flush_stall", stall, 0);
        step();
        req_valid = 1'b0; int_flush = 1'b0;
        @(negedge clk);
        chk("done_flush_busy", busy, 0);
        step();

        // flush in DIV_REQ with tready low -> IDLE at once
        rdy_dly = 2; res_dly = 1;
        req_valid = 1'b1; req_op = OP_DIVU; src_a = 32'd9; src_b = 32'd3;
        step();
        req_valid = 1'b0; int_flush = 1'b1;
        @(negedge clk);
        chk("divreq_flush_tvalid", div_tvalid, 1);
        chk("divreq_flush_stall", stall, 0);
        step();
        int_flush = 1'b0;
        @(negedge clk);
        chk("divreq_flush_busy", busy, 0);
        chk("divreq_flush_tvalid_off", div_tvalid, 0);
        step();

        // flush in DIV_REQ with tready high -> DRAIN until the response
        rdy_dly = 0; res_dly = 2;
        req_valid = 1'b1; req_op = OP_DIVU; src_a = 32'd9; src_b = 32'd3;
        step();
        req_valid = 1'b0; int_flush = 1'b1;
        step();
        int_flush = 1'b0;
        @(negedge clk);
        chk("divreq_drain_busy", busy, 1);
        chk("divreq_drain_stall", stall, 0);
        step();
        @(negedge clk);
        chk("divreq_drain_we", hilo_we, 0);
        step();
        @(negedge clk);
        chk("divreq_drain_idle", busy, 0);
        step();

        // flush in DIV_BUSY, new DIV waits in DRAIN, only its own result lands
        rdy_dly = 0; res_dly = 4;
        req_valid = 1'b1; req_op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        chk("drain_first_stall", stall, 1);
        step();
        step();
        step();
        req_valid = 1'b0; int_flush = 1'b1;
        @(negedge clk);
        chk("divbusy_flush_stall", stall, 0);
        chk("divbusy_flush_we", hilo_we, 0);
        step();
        int_flush = 1'b0; req_valid = 1'b1; req_op = OP_DIV;
        src_a = 32'hFFFF_FFF9; src_b = 32'd2;
        idx = 0; nlow = 0; we = 2'b00; wd = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (hilo_we != 2'b00) begin
                idx = i;
                we  = hilo_we;
                wd  = hilo_wdata;
                break;
            end
            if (!stall) nlow++;
            step();
        end
        step();
        req_valid = 1'b0;
        chk("drain_write_cycle", idx, 9);
        chk("drain_stall_gaps", nlow, 0);
        chk("drain_second_we", we, 2'b11);
        chk("drain_second_wdata", wd, 64'hFFFF_FFFF_FFFF_FFFD);

        // reset in DIV_BUSY abandons the transaction
        rdy_dly = 0; res_dly = 10;
        req_valid = 1'b1; req_op = OP_DIVU; src_a = 32'd9; src_b = 32'd3;
        step();
        step();
        rst_n = 1'b0; req_valid = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_stall", stall, 0);
        nlow = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (hilo_we != 2'b00 || div_tvalid) nlow++;
        end
        chk("midrst_quiet", nlow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
